// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: baud-tick synchronizer, byte FIFO, and frame shifter
// producing start / LSB-first data / optional parity / stop bit(s) on txd.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | line idle high, waiting for a tick with data queued
// S_START  | start bit (0) on the line
// S_DATA   | data bits, LSB first, bit_cnt = bit on the line
// S_PARITY | parity bit on the line
// S_STOP   | stop bit(s) on the line, stop_cnt = stop bit index
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clkin,
    input  logic                          rst,
    input  logic                          baud_clk,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic                 s1, s2, s3;
    logic                 tick;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;
    logic                 fifo_nonempty;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 stop_last;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    // baud_clk is asynchronous: two flops for metastability, a third for edge detect
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= baud_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    assign fifo_nonempty = (fifo_count != '0);
    assign tx_ready      = (fifo_count < CW'(FIFO_DEPTH));
    assign push          = tx_valid && tx_ready;
    assign stop_last     = (stop_cnt == 1'(STOP_BITS - 1));
    assign pop           = tick && fifo_nonempty &&
                           ((state == S_IDLE) || ((state == S_STOP) && stop_last));
    assign head          = mem[rd_ptr];

    always_ff @(posedge clkin) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (fifo_nonempty) begin
                        shreg   <= head;
                        par_bit <= parity_of(head);
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    txd     <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            txd   <= par_bit;
                            state <= S_PARITY;
                        end else begin
                            txd      <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
                        end
                    end else begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    txd      <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= S_STOP;
                end
                S_STOP: begin
                    if (stop_last) begin
                        // Queued byte starts immediately: no idle bit between frames
                        if (fifo_nonempty) begin
                            shreg   <= head;
                            par_bit <= parity_of(head);
                            txd     <= 1'b0;
                            state   <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four parameterisations sharing clock,
// reset and baud; each scenario task checks its own expected line samples.
module tb_uart_tx_serializer;

    logic             clkin    = 1'b0;
    logic             rst      = 1'b1;
    logic             baud_clk = 1'b0;
    logic [7:0]       tx_data  = 8'h00;
    logic [3:0]       vld      = 4'h0;
    logic [3:0]       rdy;
    logic [3:0]       txd;
    logic [3:0]       busy;
    logic [3:0][2:0]  cnt;

    int tests = 0;
    int fails = 0;

    logic       cap_txd  [64];
    logic       cap_busy [64];
    logic [2:0] cap_cnt  [64];

    always #5 clkin = ~clkin;

    // Baud period of 20 clkin cycles, edges placed on clkin falling edges
    initial begin
        forever begin
            repeat (10) @(negedge clkin);
            baud_clk = ~baud_clk;
        end
    end

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clkin(clkin), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clkin(clkin), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clkin(clkin), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
        .clkin(clkin), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .txd(txd[3]), .busy(busy[3]), .fifo_count(cnt[3]));

    // Mid-bit sample point: 10 clkin cycles after a baud rising edge
    task automatic sync_point();
        @(posedge baud_clk);
        repeat (10) @(negedge clkin);
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        tx_data  = d;
        vld[idx] = 1'b1;
        @(posedge clkin);
        @(negedge clkin);
        vld[idx] = 1'b0;
    endtask

    task automatic capture(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge baud_clk);
            repeat (10) @(negedge clkin);
            cap_txd[i]  = txd[idx];
            cap_busy[i] = busy[idx];
            cap_cnt[i]  = cnt[idx];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        tests++; if (txd !== 4'hF)  begin fails++; $display("FAIL reset_txd: got %b expected 1111", txd); end
        tests++; if (busy !== 4'h0) begin fails++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        tests++; if (cnt !== 12'h0) begin fails++; $display("FAIL reset_count: got %h expected 000", cnt); end
        tests++; if (rdy !== 4'hF)  begin fails++; $display("FAIL reset_ready: got %b expected 1111", rdy); end
        repeat (3) @(negedge clkin);
        rst = 1'b1;
        repeat (4) @(negedge clkin);
        tests++; if (txd !== 4'hF)  begin fails++; $display("FAIL post_reset_txd: got %b expected 1111", txd); end
        tests++; if (busy !== 4'h0) begin fails++; $display("FAIL post_reset_busy: got %b expected 0000", busy); end
    endtask

    task automatic test_basic_frame();
        logic [10:0] exp_t;
        logic [10:0] exp_b;
        exp_t = 11'b1_1_01010101_0;
        exp_b = 11'b0_1111111111;
        sync_point();
        push(0, 8'h55);
        tests++; if (cnt[0] !== 3'd1) begin fails++; $display("FAIL basic_count_push: got %0d expected 1", cnt[0]); end
        capture(0, 11);
        tests++; if (cap_cnt[0] !== 3'd0) begin fails++; $display("FAIL basic_count_tick: got %0d expected 0", cap_cnt[0]); end
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (cap_txd[i] !== exp_t[i]) begin
                fails++; $display("FAIL basic_txd[%0d]: got %b expected %b", i, cap_txd[i], exp_t[i]);
            end
            tests++;
            if (cap_busy[i] !== exp_b[i]) begin
                fails++; $display("FAIL basic_busy[%0d]: got %b expected %b", i, cap_busy[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_parity();
        int          idx   [3];
        logic [7:0]  dat   [3];
        logic [11:0] exp_t [3];
        logic [11:0] exp_b;
        idx[0] = 1; dat[0] = 8'h07; exp_t[0] = 12'b1_1_1_00000111_0;
        idx[1] = 2; dat[1] = 8'h00; exp_t[1] = 12'b1_1_1_00000000_0;
        idx[2] = 2; dat[2] = 8'h01; exp_t[2] = 12'b1_1_0_00000001_0;
        exp_b = 12'b0_11111111111;
        for (int k = 0; k < 3; k++) begin
            sync_point();
            push(idx[k], dat[k]);
            capture(idx[k], 12);
            for (int i = 0; i < 12; i++) begin
                tests++;
                if (cap_txd[i] !== exp_t[k][i]) begin
                    fails++; $display("FAIL parity%0d_txd[%0d]: got %b expected %b", k, i, cap_txd[i], exp_t[k][i]);
                end
                tests++;
                if (cap_busy[i] !== exp_b[i]) begin
                    fails++; $display("FAIL parity%0d_busy[%0d]: got %b expected %b", k, i, cap_busy[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] got;
        logic       seen_full;
        seen_full = 1'b0;
        sync_point();
        fork
            begin
                int   n;
                int   cyc;
                logic r;
                n   = 0;
                cyc = 0;
                while (n < 6 && cyc < 3000) begin
                    @(negedge clkin);
                    tx_data = 8'hA0 + 8'(n);
                    vld[0]  = 1'b1;
                    if (cnt[0] == 3'd4 && !seen_full) begin
                        seen_full = 1'b1;
                        tests++;
                        if (rdy[0] !== 1'b0) begin
                            fails++; $display("FAIL full_ready: got %b expected 0", rdy[0]);
                        end
                    end
                    r = rdy[0];
                    @(posedge clkin);
                    if (r) n++;
                    cyc++;
                end
                @(negedge clkin);
                vld[0] = 1'b0;
                tests++;
                if (n != 6) begin fails++; $display("FAIL full_pushes: got %0d expected 6", n); end
            end
            begin
                capture(0, 61);
            end
        join
        tests++;
        if (!seen_full) begin fails++; $display("FAIL full_reached: got 0 expected 1"); end
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 8; b++) got[b] = cap_txd[f*10 + 1 + b];
            tests++;
            if (cap_txd[f*10] !== 1'b0) begin
                fails++; $display("FAIL full_start%0d: got %b expected 0", f, cap_txd[f*10]);
            end
            tests++;
            if (got !== 8'hA0 + 8'(f)) begin
                fails++; $display("FAIL full_byte%0d: got %h expected %h", f, got, 8'hA0 + 8'(f));
            end
            tests++;
            if (cap_txd[f*10 + 9] !== 1'b1) begin
                fails++; $display("FAIL full_stop%0d: got %b expected 1", f, cap_txd[f*10 + 9]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            tests++;
            if (cap_busy[i] !== 1'b1) begin
                fails++; $display("FAIL full_busy[%0d]: got %b expected 1", i, cap_busy[i]);
            end
        end
        tests++; if (cap_txd[60] !== 1'b1)  begin fails++; $display("FAIL full_idle_txd: got %b expected 1", cap_txd[60]); end
        tests++; if (cap_busy[60] !== 1'b0) begin fails++; $display("FAIL full_idle_busy: got %b expected 0", cap_busy[60]); end
    endtask

    task automatic test_stop_bits();
        logic [11:0] exp_t;
        int          cyc;
        exp_t = 12'b0_1_1_11111111_0;
        sync_point();
        push(3, 8'hFF);
        push(3, 8'h00);
        capture(3, 12);
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (cap_txd[i] !== exp_t[i]) begin
                fails++; $display("FAIL stop2_txd[%0d]: got %b expected %b", i, cap_txd[i], exp_t[i]);
            end
            tests++;
            if (cap_busy[i] !== 1'b1) begin
                fails++; $display("FAIL stop2_busy[%0d]: got %b expected 1", i, cap_busy[i]);
            end
        end
        cyc = 0;
        while (busy[3] !== 1'b0 && cyc < 600) begin
            @(negedge clkin);
            cyc++;
        end
        tests++;
        if (busy[3] !== 1'b0) begin fails++; $display("FAIL stop2_drain: got busy %b expected 0", busy[3]); end
    endtask

    task automatic test_reset_mid_frame();
        sync_point();
        push(0, 8'h3C);
        push(0, 8'h5A);
        push(0, 8'hC3);
        capture(0, 3);
        tests++; if (cnt[0] !== 3'd2) begin fails++; $display("FAIL midrst_setup_count: got %0d expected 2", cnt[0]); end
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL midrst_setup_busy: got %b expected 1", busy[0]); end
        repeat (3) @(negedge clkin);
        #2 rst = 1'b0;
        #1;
        tests++; if (txd[0] !== 1'b1)  begin fails++; $display("FAIL midrst_txd: got %b expected 1", txd[0]); end
        tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy[0]); end
        tests++; if (cnt[0] !== 3'd0)  begin fails++; $display("FAIL midrst_count: got %0d expected 0", cnt[0]); end
        repeat (4) @(negedge clkin);
        rst = 1'b1;
        capture(0, 12);
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (cap_txd[i] !== 1'b1 || cap_busy[i] !== 1'b0) begin
                fails++; $display("FAIL midrst_after[%0d]: got txd %b busy %b expected txd 1 busy 0", i, cap_txd[i], cap_busy[i]);
            end
        end
    endtask

    task automatic test_push_pop();
        int cyc;
        sync_point();
        push(0, 8'hB0);
        push(0, 8'hB1);
        tests++; if (cnt[0] !== 3'd2) begin fails++; $display("FAIL pp_setup_count: got %0d expected 2", cnt[0]); end
        // The idle pop lands on the third clkin rise after the baud rise
        @(posedge baud_clk);
        @(posedge clkin);
        @(posedge clkin);
        @(negedge clkin);
        tx_data = 8'hB2;
        vld[0]  = 1'b1;
        @(posedge clkin);
        @(negedge clkin);
        vld[0] = 1'b0;
        tests++; if (cnt[0] !== 3'd2)  begin fails++; $display("FAIL pp_same_cycle_count: got %0d expected 2", cnt[0]); end
        tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL pp_popped_busy: got %b expected 1", busy[0]); end
        push(0, 8'hB3);
        push(0, 8'hB4);
        tests++; if (cnt[0] !== 3'd4) begin fails++; $display("FAIL pp_full_count: got %0d expected 4", cnt[0]); end
        tx_data = 8'hB5;
        vld[0]  = 1'b1;
        cyc = 0;
        while (cnt[0] == 3'd4 && cyc < 600) begin
            @(negedge clkin);
            cyc++;
        end
        tests++; if (cnt[0] !== 3'd3) begin fails++; $display("FAIL pp_refused_count: got %0d expected 3", cnt[0]); end
        tests++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL pp_ready_after_pop: got %b expected 1", rdy[0]); end
        @(posedge clkin);
        @(negedge clkin);
        vld[0] = 1'b0;
        tests++; if (cnt[0] !== 3'd4) begin fails++; $display("FAIL pp_accept_next: got %0d expected 4", cnt[0]); end
        cyc = 0;
        while (busy[0] !== 1'b0 && cyc < 2500) begin
            @(negedge clkin);
            cyc++;
        end
        tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL pp_drain: got busy %b expected 0", busy[0]); end
        tests++; if (cnt[0] !== 3'd0)  begin fails++; $display("FAIL pp_drain_count: got %0d expected 0", cnt[0]); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic_frame();
        test_parity();
        test_fifo_full();
        test_stop_bits();
        test_reset_mid_frame();
        test_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer for the serial I/O subsystem, directly downstream of the baud clock generator.
- Samples the generator's square-wave output (baud_clk) into single-cycle bit ticks in the clkin domain.
- Buffers bytes from the CPU/bus side in a small FIFO with a valid/ready handshake.
- Shifts each byte out on txd as an asynchronous frame: start bit, data LSB-first, optional parity, stop bit(s).

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clkin  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
baud_clk  input  1  baud square wave from the clock generator; asynchronous to clkin; one bit period per rising edge
tx_data  input  DATA_BITS  byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  FIFO can accept; transfer when tx_valid && tx_ready at clkin edge
txd  output  1  serial line, idle high
busy  output  1  high while a frame is in progress (state != IDLE)
fifo_count  output  clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset:
  - rst low forces state IDLE, txd = 1, busy = 0, FIFO empty (fifo_count = 0), synchronizer flops = 0, shift/bit counters = 0.
  - Reset applies immediately, including mid-frame; the partial frame is aborted and FIFO contents are discarded.
- Baud tick:
  - baud_clk passes through a 2-flop synchronizer plus an edge flop; tick = s2 & ~s3.
  - Exactly one clkin-cycle pulse per baud_clk rising edge; latency 2-3 clkin cycles.
  - If baud_clk is high at reset release, one tick occurs about 2 cycles later. This is harmless in IDLE with an empty FIFO.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - tx_ready = (fifo_count < FIFO_DEPTH), with no combinational dependence on a same-cycle pop. When full, a push is refused even if a pop occurs that cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A pop on an empty FIFO cannot occur; the FSM pops only when fifo_count != 0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on tick.
  - IDLE: txd = 1. On tick with fifo_count != 0: pop the head into the shift register, compute the parity bit (even: ^data; odd: ~^data), txd <= 0, go to START.
  - START: on tick, txd <= shreg[0], shift right, bit_cnt <= 0, go to DATA.
  - DATA: on tick:
    - if bit_cnt == DATA_BITS-1: if PARITY != 0, txd <= parity bit and go to PARITY; else txd <= 1 and go to STOP with stop_cnt = 0;
    - otherwise txd <= next bit and bit_cnt++.
  - PARITY: on tick, txd <= 1, go to STOP with stop_cnt = 0.
  - STOP: on tick:
    - if stop_cnt == STOP_BITS-1: if fifo_count != 0, pop, txd <= 0 and go to START (back-to-back, no idle bit); else go to IDLE with txd = 1;
    - otherwise stop_cnt++.
- Timing:
  - Each line level is held exactly one tick-to-tick interval.
  - Frame length = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS ticks.
  - busy rises with the start bit and falls at the end of the final stop bit when the FIFO is empty.
- txd is registered; it never glitches between ticks.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP_BITS=1: push 0x55 while idle -> on successive ticks txd = 0,1,0,1,0,1,0,1,0,1,1(idle); busy high for exactly 10 ticks; fifo_count 1 -> 0 at the first tick.
2. PARITY=1, push 0x07 -> parity bit 1; PARITY=2, push 0x00 -> parity bit 1; PARITY=2, push 0x01 -> parity bit 0; frame is 11 ticks.
3. FIFO_DEPTH=4, slow baud, hold tx_valid with 0xA0..0xA5 -> tx_ready falls when fifo_count = 4; no byte is lost or duplicated; frames go out back-to-back (stop bit followed directly by start bit); busy stays high throughout; the order is preserved.
4. STOP_BITS=2, push 0xFF -> start 0, eight 1s, then txd = 1 for two ticks before the next start of a queued byte.
5. Reset pulsed low in the middle of the DATA state with 2 bytes queued -> txd = 1 and busy = 0 immediately (asynchronously), fifo_count = 0; after release, idle line with no residual frame.
6. Simultaneous push and pop at fifo_count = 2 -> fifo_count stays 2; push at full with a same-cycle pop -> refused (tx_ready = 0); data is accepted on the next cycle.
